// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg: shared fetch-entry layout, control states and PC step.
package riscv_fetch_pkg;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_e;

    localparam logic [63:0] PC_INC = 64'd4;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous circular FIFO with flush, count and full/empty flags.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    head_q, tail_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = count_q == '0;
    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign do_pop  = pop_i && !empty_o;
    // A push into a full queue is legal when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[head_q];
    assign count_o = count_q;

    // Occupancy changes by +1, -1 or 0 depending on which side moved.
    always_comb begin
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) tail_q <= tail_q + 1'b1;
            if (do_pop) head_q <= head_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[tail_q] <= wdata_i;
    end

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: sequential instruction fetch with redirect, fault and end-of-memory halt.
module fetch_controller
    import riscv_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int          IMEM_BYTES = 88,
    parameter int          QDEPTH     = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] Inst_Address,
    input  logic [31:0] Instruction,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        if_ready,
    output logic        if_valid,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr,
    output logic        fetch_done,
    output logic        fetch_fault
);

    logic [63:0]          fetch_pc_q, fetch_pc_d;
    logic                 fetch_fault_q, fetch_fault_d;
    fetch_state_e         state;
    fetch_entry_t         head, tail_entry;
    logic                 push, pop, q_full, q_empty;
    logic [$clog2(QDEPTH):0] q_count;

    assign Inst_Address = fetch_pc_q;
    assign fetch_fault  = fetch_fault_q;
    // 65-bit compare keeps a PC near 2^64 from wrapping back into range.
    assign fetch_done   = ({1'b0, fetch_pc_q} + 65'(PC_INC)) > 65'(IMEM_BYTES);
    assign state        = (fetch_fault_q || fetch_done) ? HALT : FETCH;
    assign pop          = if_valid && if_ready;
    assign push         = !redirect_valid && state == FETCH && (!q_full || pop);
    assign tail_entry   = '{pc: fetch_pc_q, instr: Instruction};
    assign if_valid     = q_count != '0;
    assign if_pc        = q_empty ? 64'd0 : head.pc;
    assign if_instr     = q_empty ? 32'd0 : head.instr;

    fetch_queue #(
        .DEPTH(QDEPTH),
        .WIDTH($bits(fetch_entry_t))
    ) u_queue (
        .clk    (clk),
        .reset  (reset),
        .push_i (push),
        .pop_i  (pop && !redirect_valid),
        .flush_i(redirect_valid),
        .wdata_i(tail_entry),
        .rdata_o(head),
        .count_o(q_count),
        .full_o (q_full),
        .empty_o(q_empty)
    );

    // Redirect wins over sequential advance; a misaligned target only raises the fault.
    always_comb begin
        fetch_pc_d    = redirect_valid ? (redirect_pc[1:0] == 2'b00 ? redirect_pc : fetch_pc_q)
                                       : (push ? fetch_pc_q + PC_INC : fetch_pc_q);
        fetch_fault_d = redirect_valid ? (redirect_pc[1:0] != 2'b00) : fetch_fault_q;
    end

    // Fetch PC and sticky fault register.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            fetch_fault_q <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

endmodule
